// File: rtl/regfile_wb_ctrl_if.sv
// rtl/regfile_wb_ctrl_if.sv - write-back request and reservation bundle for regfile_wb_ctrl
//
// master: requester side (write-back units and issue logic)
// slave : regfile_wb_ctrl side
//   wr_valid_i  [NUM_WR]            write request per requester
//   wr_ready_o  [NUM_WR]            grant per requester, one-hot or zero
//   wr_addr_i   [NUM_WR][AW]        destination register per requester
//   wr_data_i   [NUM_WR][REG_WIDTH] write data per requester
//   rsv_valid_i                     reserve request
//   rsv_addr_i  [AW]                register to reserve
//   rsv_ready_o                     reservation accepted
interface regfile_wb_ctrl_if #(
  parameter int NUM_WR    = 2,
  parameter int NUM_REG   = 32,
  parameter int REG_WIDTH = 32
);
  localparam int AW = $clog2(NUM_REG);

  logic [NUM_WR-1:0]                wr_valid_i;
  logic [NUM_WR-1:0]                wr_ready_o;
  logic [NUM_WR-1:0][AW-1:0]        wr_addr_i;
  logic [NUM_WR-1:0][REG_WIDTH-1:0] wr_data_i;
  logic                             rsv_valid_i;
  logic [AW-1:0]                    rsv_addr_i;
  logic                             rsv_ready_o;

  modport master (
    output wr_valid_i, wr_addr_i, wr_data_i, rsv_valid_i, rsv_addr_i,
    input  wr_ready_o, rsv_ready_o
  );

  modport slave (
    input  wr_valid_i, wr_addr_i, wr_data_i, rsv_valid_i, rsv_addr_i,
    output wr_ready_o, rsv_ready_o
  );
endinterface

// File: rtl/regfile_wb_ctrl.sv
// rtl/regfile_wb_ctrl.sv - round-robin write-back arbiter and busy scoreboard for regfile
//
// Ports:
//   clk_i      single clock
//   rst_i      synchronous active-high reset
//   wb         regfile_wb_ctrl_if.slave: write requests, grants, reservations
//   busy_o     scoreboard, one bit per register
//   rd_en_o    registered write enable to regfile
//   rd_addr_o  registered write address to regfile
//   rd_data_o  registered write data to regfile
module regfile_wb_ctrl #(
  parameter int NUM_WR    = 2,
  parameter bit ZERO_REG  = 1'b1,
  parameter int NUM_REG   = 32,
  parameter int REG_WIDTH = 32,
  localparam int AW       = $clog2(NUM_REG)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  regfile_wb_ctrl_if.slave     wb,
  output logic [NUM_REG-1:0]   busy_o,
  output logic                 rd_en_o,
  output logic [AW-1:0]        rd_addr_o,
  output logic [REG_WIDTH-1:0] rd_data_o
);

  // Pointer width; one extra bit in the search sum so the wrap compare
  // works for non-power-of-two requester counts.
  localparam int PW = (NUM_WR > 1) ? $clog2(NUM_WR) : 1;

  logic [PW-1:0]        ptr_q;
  logic [PW-1:0]        ptr_d;
  logic [PW-1:0]        gnt_idx;
  logic                 gnt_found;
  logic [PW:0]          search_sum;
  logic [PW-1:0]        search_idx;
  logic [NUM_WR-1:0]    gnt;

  logic                 rd_en_q;
  logic [AW-1:0]        rd_addr_q;
  logic [REG_WIDTH-1:0] rd_data_q;
  logic                 rd_en_d;

  logic [NUM_REG-1:0]   busy_q;
  logic [NUM_REG-1:0]   busy_d;
  logic                 rsv_is_zero;
  logic                 rsv_ready;
  logic                 wr_is_zero;

  // ---------------------------------------------------------------------
  // Round-robin arbitration: first valid requester at or after ptr_q.
  // ---------------------------------------------------------------------
  always_comb begin
    gnt_idx    = '0;
    gnt_found  = 1'b0;
    search_sum = '0;
    search_idx = '0;
    for (int i = 0; i < NUM_WR; i++) begin
      search_sum = {1'b0, ptr_q} + (PW+1)'(i);
      if (search_sum >= (PW+1)'(NUM_WR)) begin
        search_sum = search_sum - (PW+1)'(NUM_WR);
      end
      search_idx = search_sum[PW-1:0];
      if (!gnt_found && wb.wr_valid_i[search_idx]) begin
        gnt_found = 1'b1;
        gnt_idx   = search_idx;
      end
    end
  end

  always_comb begin
    gnt = '0;
    if (gnt_found) begin
      gnt[gnt_idx] = 1'b1;
    end
  end

  assign wb.wr_ready_o = gnt;

  always_comb begin
    ptr_d = ptr_q;
    if (gnt_found) begin
      if (gnt_idx == PW'(NUM_WR - 1)) begin
        ptr_d = '0;
      end else begin
        ptr_d = gnt_idx + PW'(1);
      end
    end
  end

  // Writes to the hardwired zero register complete the handshake but never
  // reach the file.
  assign wr_is_zero = ZERO_REG && (wb.wr_addr_i[gnt_idx] == '0);
  assign rd_en_d    = gnt_found && !wr_is_zero;

  // ---------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------
  assign rsv_is_zero    = ZERO_REG && (wb.rsv_addr_i == '0);
  assign rsv_ready      = rsv_is_zero || !busy_q[wb.rsv_addr_i];
  assign wb.rsv_ready_o = rsv_ready;

  // Release uses the registered write that regfile captures at this edge;
  // a same-address set cannot coincide because rsv_ready is low while busy.
  always_comb begin
    busy_d = busy_q;
    if (rd_en_q) begin
      busy_d[rd_addr_q] = 1'b0;
    end
    if (wb.rsv_valid_i && rsv_ready && !rsv_is_zero) begin
      busy_d[wb.rsv_addr_i] = 1'b1;
    end
    if (ZERO_REG) begin
      busy_d[0] = 1'b0;
    end
  end

  // ---------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr_q     <= '0;
      busy_q    <= '0;
      rd_en_q   <= 1'b0;
      rd_addr_q <= '0;
      rd_data_q <= '0;
    end else begin
      ptr_q   <= ptr_d;
      busy_q  <= busy_d;
      rd_en_q <= rd_en_d;
      if (gnt_found) begin
        rd_addr_q <= wb.wr_addr_i[gnt_idx];
        rd_data_q <= wb.wr_data_i[gnt_idx];
      end
    end
  end

  assign busy_o    = busy_q;
  assign rd_en_o   = rd_en_q;
  assign rd_addr_o = rd_addr_q;
  assign rd_data_o = rd_data_q;

  // ---------------------------------------------------------------------
  // Invariants
  // ---------------------------------------------------------------------
  a_gnt_onehot0 : assert property (@(posedge clk_i) disable iff (rst_i)
    $onehot0(wb.wr_ready_o));

  a_gnt_has_valid : assert property (@(posedge clk_i) disable iff (rst_i)
    (wb.wr_ready_o & ~wb.wr_valid_i) == '0);

  a_zero_never_busy : assert property (@(posedge clk_i) disable iff (rst_i)
    !ZERO_REG || !busy_o[0]);

endmodule
